// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// The state encoding is exported so checkers can decode the debug state port.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = a - b, borrow set when a < b.
// The serial datapath chains two of these to form a full subtract cell.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b;
    assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B mod 2^WIDTH, one bit per clock, LSB first.
// Borrow is the final borrow out, i.e. 1 exactly when A < B.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high. in_ready is high only in IDLE, out_valid only in DONE; both are decoded
    // from the state register, so neither depends combinationally on any input.

    sub_state_t       state;
    sub_state_t       state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt;

    logic d_half;
    logic b_half;
    logic d_bit;
    logic b_chain;
    logic borrow_next;
    logic last_bit;

    // Full subtract of the current LSB: first cell subtracts b, second subtracts the borrow-in.
    half_subtractor u_hs_ab (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .diff   (d_half),
        .borrow (b_half)
    );

    half_subtractor u_hs_bin (
        .a      (d_half),
        .b      (borrow_q),
        .diff   (d_bit),
        .borrow (b_chain)
    );

    assign borrow_next = b_half | b_chain;
    assign last_bit    = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
                    borrow_q <= borrow_next;
                    // Holding at WIDTH-1 keeps the counter from wrapping for any WIDTH.
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Diff      = diff_q;
    assign Borrow    = borrow_q;
    assign dbg_state = state;

endmodule
